// File: rtl/vga_frame_gen.sv
// VGA timing generator and 8-bar test pattern; whole-frame inversion follows pps, latched at pixel (0,0).
// Build with BORDER_EN defined to add a fixed white one-pixel border around the visible area.
module vga_frame_gen #(
    parameter int H_VISIBLE = 1680,
    parameter int H_FP      = 104,
    parameter int H_SYNC    = 184,
    parameter int H_BP      = 288,
    parameter int V_VISIBLE = 1050,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pps,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       video_active,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] H_VIS_L  = 12'(H_VISIBLE - 1);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] V_VIS_L  = 11'(V_VISIBLE - 1);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] bar_pix_q, bar_pix_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        inv_frame_q, inv_frame_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        video_active_q, video_active_d;
    logic        frame_start_q, frame_start_d;

    logic        line_end;
    logic        frame_origin;
    logic        visible;
    logic        inv_cur;
    logic [11:0] bar_rgb;
    logic [11:0] pix_rgb;

    always_comb begin
        line_end     = (h_cnt_q == H_LAST);
        frame_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);

        h_cnt_d = line_end ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (line_end) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end

        // Bar index tracks h_cnt/BAR_W incrementally; it runs on harmlessly through blanking.
        bar_pix_d = bar_pix_q + 12'd1;
        bar_idx_d = bar_idx_q;
        if (line_end) begin
            bar_pix_d = 12'd0;
            bar_idx_d = 3'd0;
        end else if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = 12'd0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        // Pixel (0,0) already uses the freshly sampled pps so the whole new frame is consistent.
        inv_cur     = frame_origin ? pps : inv_frame_q;
        inv_frame_d = inv_cur;

        case (bar_idx_q)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
        pix_rgb = inv_cur ? ~bar_rgb : bar_rgb;
`ifdef BORDER_EN
        if ((h_cnt_q == 12'd0) || (h_cnt_q == H_VIS_L) ||
            (v_cnt_q == 11'd0) || (v_cnt_q == V_VIS_L)) begin
            pix_rgb = 12'hFFF;
        end
`endif

        visible        = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        rgb_d          = visible ? pix_rgb : 12'h000;
        video_active_d = visible;
        frame_start_d  = frame_origin;
        hsync_d        = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d        = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q        <= 12'd0;
            v_cnt_q        <= 11'd0;
            bar_pix_q      <= 12'd0;
            bar_idx_q      <= 3'd0;
            inv_frame_q    <= 1'b0;
            hsync_q        <= ~HSYNC_POL;
            vsync_q        <= ~VSYNC_POL;
            rgb_q          <= 12'h000;
            video_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            bar_pix_q      <= bar_pix_d;
            bar_idx_q      <= bar_idx_d;
            inv_frame_q    <= inv_frame_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            rgb_q          <= rgb_d;
            video_active_q <= video_active_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign red          = rgb_q[11:8];
    assign green        = rgb_q[7:4];
    assign blue         = rgb_q[3:0];
    assign video_active = video_active_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_frame_gen.sv
// Scoreboarded bench for vga_frame_gen on a shrunk raster so many whole frames fit in a short run.
module tb_vga_frame_gen;

    localparam int T_HV  = 32;
    localparam int T_HFP = 3;
    localparam int T_HS  = 5;
    localparam int T_HBP = 4;
    localparam int T_VV  = 6;
    localparam int T_VFP = 1;
    localparam int T_VS  = 3;
    localparam int T_VBP = 2;
    localparam bit T_HPOL = 1'b0;
    localparam bit T_VPOL = 1'b1;
    localparam int T_HT = T_HV + T_HFP + T_HS + T_HBP;
    localparam int T_VT = T_VV + T_VFP + T_VS + T_VBP;
    localparam int T_BW = T_HV / 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pps = 1'b0;
    logic       hsync, vsync, video_active, frame_start;
    logic [3:0] red, green, blue;

    int m_h = 0;
    int m_v = 0;
    bit m_inv = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    vga_frame_gen #(
        .H_VISIBLE(T_HV), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_VISIBLE(T_VV), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
        .HSYNC_POL(T_HPOL), .VSYNC_POL(T_VPOL)
    ) dut (
        .clk(clk), .reset(reset), .pps(pps),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .video_active(video_active), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bar_colour(input int idx);
        case (idx)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Packed as {hsync, vsync, red, green, blue, video_active, frame_start}.
    function automatic logic [15:0] expect_px(input int h, input int v, input bit inv);
        bit vis;
        bit hs;
        bit vs;
        logic [11:0] rgb;
        vis = (h < T_HV) && (v < T_VV);
        hs  = (h >= T_HV + T_HFP && h < T_HV + T_HFP + T_HS) ? T_HPOL : ~T_HPOL;
        vs  = (v >= T_VV + T_VFP && v < T_VV + T_VFP + T_VS) ? T_VPOL : ~T_VPOL;
        rgb = 12'h000;
        if (vis) begin
            rgb = bar_colour(h / T_BW);
            if (inv) rgb = ~rgb;
`ifdef BORDER_EN
            if (h == 0 || h == T_HV - 1 || v == 0 || v == T_VV - 1) rgb = 12'hFFF;
`endif
        end
        return {hs, vs, rgb, vis, (h == 0 && v == 0)};
    endfunction

    task automatic step(input string tag);
        logic [15:0] e;
        logic [15:0] got;
        int ph;
        int pv;
        bit inv_eff;
        ph = m_h;
        pv = m_v;
        if (reset) begin
            e = {~T_HPOL, ~T_VPOL, 12'h000, 1'b0, 1'b0};
            m_h = 0;
            m_v = 0;
            m_inv = 1'b0;
        end else begin
            inv_eff = (m_h == 0 && m_v == 0) ? pps : m_inv;
            e = expect_px(m_h, m_v, inv_eff);
            m_inv = inv_eff;
            if (m_h == T_HT - 1) begin
                m_h = 0;
                m_v = (m_v == T_VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {hsync, vsync, red, green, blue, video_active, frame_start};
        e = exp_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s h=%0d v=%0d observed=%h expected=%h", tag, ph, pv, got, e);
        end
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        for (int i = 0; i < T_HT * T_VT + 1; i++) begin
            if (m_h == h && m_v == v) return;
            step(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        pps = 1'b0;
        run_cycles(6, "rst_hold");

        reset = 1'b0;
        run_cycles(2 * T_HT * T_VT, "frame_plain");

        run_to(10, 3, "pre_pps");
        pps = 1'b1;
        run_to(0, 0, "pps_up_cur");
        run_to(12, 2, "pps_up_next");
        pps = 1'b0;
        run_to(0, 0, "pps_down_hold");
        run_cycles(T_HT * T_VT, "pps_down_next");

        pps = 1'b1;
        run_to(20, 3, "pre_reset");
        reset = 1'b1;
        run_cycles(2, "mid_reset");
        reset = 1'b0;
        run_cycles(T_HT * T_VT + T_HT, "post_reset");

        reset = 1'b1;
        run_cycles(T_HT + 3, "long_reset");
        reset = 1'b0;
        pps = 1'b0;

        for (int f = 0; f < 3 * T_VT; f++) begin
            pps = 1'($urandom_range(0, 1));
            run_cycles(T_HT - 7 + int'($urandom_range(0, 14)), "rand_pps");
        end
        run_to(0, 0, "tail");
        run_cycles(T_HT * T_VT, "tail_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
